fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter placed in the write-clock domain in front of the team's asynchronous gray-pointer FIFO. It shares the FIFO's single write port (wr_en/din/full) among NUM_REQ requesters using valid/ready handshakes. Each grant is burst-locked: it lasts until the requester's last word, a MAX_BURST word limit, or the requester going idle. All logic runs on wr_clk; the read side of the FIFO is untouched.

## Interface
- NUM_REQ, default 4: number of requesters, 2..16.
- DATA_WIDTH, default 8: word width; must match the FIFO.
- MAX_BURST, default 8: maximum words per grant, 1..256.
- IDW, localparam = clog2(NUM_REQ): grant ID width.

- wr_clk  in  1  write-domain clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_last  in  NUM_REQ  per-requester last-word-of-packet flag, qualified by req_valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed words; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester accept; at most one bit is high.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_din  out  DATA_WIDTH  FIFO write data.
- gnt_valid  out  1  a grant is active (state BURST).
- gnt_id  out  IDW  index of the granted requester.

## Operation
- FSM states:
  - IDLE: no grant.
  - BURST: one requester holds the write port.
- IDLE → BURST when any req_valid is high. The winner is the first requester with valid high, searching from last_gnt+1 upward and wrapping modulo NUM_REQ. The winner is registered into gnt_id, and last_gnt is updated to it.
- In BURST, with g = gnt_id:
  - req_ready[g] = !fifo_full. All other req_ready bits are 0.
  - fifo_wr_en = req_valid[g] && !fifo_full. A transfer is exactly a cycle with fifo_wr_en high.
  - fifo_din always equals the req_data slice for gnt_id. Its value is meaningful only when fifo_wr_en is high.
- beat_cnt (8 bit) clears on entry to BURST and increments on each transfer.
- BURST → IDLE on the first of:
  - a transfer with req_last[g] high;
  - a transfer with beat_cnt == MAX_BURST-1;
  - a cycle with req_valid[g] low. This is treated as the requester going idle. No transfer occurs in that cycle.
- fifo_full high in BURST is a stall: no transfer, beat_cnt held, grant held. No timeout.
- Round-robin fairness: a requester that has just been granted has lowest priority in the next arbitration.

## Timing
- Reset values:
  - state IDLE
  - gnt_valid 0, gnt_id 0
  - last_gnt NUM_REQ-1, so requester 0 wins first
  - beat_cnt 0
  - fifo_wr_en 0, req_ready all 0
- Reset mid-burst: fifo_wr_en and req_ready drop immediately (asynchronously), because they are decoded from state. No partial word is written after rst rises.
- Arbitration latency: req_valid sampled high in IDLE at edge N gives gnt_valid high after edge N. The first transfer can occur in the cycle following edge N.
- Burst end: the transfer at edge M that ends the burst is followed by IDLE after M. There is exactly one IDLE bubble cycle between consecutive grants, even if requests are pending.
- Peak throughput: MAX_BURST words per MAX_BURST+1 cycles.
- fifo_full is used combinationally within the same cycle; the arbiter adds no extra full-flag latency.
- Simultaneous last and limit on one transfer: a single burst end, not two.
- A requester that raises req_valid during another requester's burst waits for that burst to end plus the one IDLE cycle.

## Structure
- The shared package fifo_pkg holds the clog2 function and the FSM state encoding (IDLE=1'b0, BURST=1'b1).
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector and last_gnt.
  - Outputs: any flag and winning index.
  - Implemented as a double-width rotate followed by a priority encode.
- Top level contains the FSM, beat_cnt, the last_gnt register and the output mux.

## Test plan
- Single requester: req 0 sends 3 words 0x11, 0x22, 0x33 with last on 0x33; FIFO not full → gnt_id=0, fifo_din sequence 0x11/0x22/0x33 on 3 consecutive cycles, then IDLE.
- Burst limit: MAX_BURST=8, req 1 holds valid for 20 words with no last, alone → writes split into 8, 8, 4 words with one-cycle bubbles; the 4-word tail ends when valid drops.
- Fairness: all 4 requesters hold valid continuously, each sending 2-word packets → grant order 0,1,2,3,0,1…; each gnt_id is held for exactly 2 transfers.
- Full stall: fifo_full high for 5 cycles in the middle of req 2's burst → req_ready[2]=0 and fifo_wr_en=0 for those cycles; the burst resumes with beat_cnt unchanged and no word lost or duplicated.
- Reset mid-burst: assert rst between edges during a burst → fifo_wr_en=0 at once; after release, requester 0 wins first regardless of the previous grant.
- Idle release: req 3 granted, drops valid after 1 word while req 1 is pending → return to IDLE, then req 1 is granted after the bubble cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the write-side FIFO logic.
package fifo_pkg;

    // Write-port arbiter FSM encoding.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Ceiling log2 for sizing index fields; returns 0 for values <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_gnt, wrapping.
module rr_pick
    import fifo_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IW      = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_gnt,
    output logic               any_c,
    output logic [IW-1:0]      win_c
);

    localparam int unsigned SW    = IW + 1;
    localparam logic [SW-1:0] N_W = SW'(NUM_REQ);
    localparam logic [IW-1:0] TOP = IW'(NUM_REQ - 1);

    logic [IW-1:0]          start;
    logic [2*NUM_REQ-1:0]   dbl_shift;
    logic [NUM_REQ-1:0]     rot;
    logic [IW-1:0]          off;
    logic                   found;
    logic [SW-1:0]          sum;

    // Rotate the doubled request vector so the search starts at last_gnt+1,
    // priority-encode the lowest set bit, then map the offset back to an index.
    always_comb begin
        any_c     = |req;
        start     = (last_gnt >= TOP) ? '0 : last_gnt + IW'(1);
        dbl_shift = {req, req} >> start;
        rot       = dbl_shift[NUM_REQ-1:0];
        off       = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = IW'(i);
            end
        end
        sum   = {1'b0, start} + {1'b0, off};
        win_c = (sum >= N_W) ? IW'(sum - N_W) : IW'(sum);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter sharing one FIFO write port among requesters.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned MAX_BURST  = 8,
    localparam int unsigned IDW        = clog2(NUM_REQ)
) (
    input  logic                          wr_clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic                          gnt_valid,
    output logic [IDW-1:0]                gnt_id
);

    localparam int unsigned   BCW       = 8;
    localparam logic [BCW-1:0] BEAT_END = BCW'(MAX_BURST - 1);

    arb_state_t           state;
    arb_state_t           state_d;
    logic [IDW-1:0]       gnt_id_d;
    logic [IDW-1:0]       last_gnt;
    logic [IDW-1:0]       last_gnt_d;
    logic [BCW-1:0]       beat_cnt;
    logic [BCW-1:0]       beat_cnt_d;

    logic                 pick_any;
    logic [IDW-1:0]       pick_win;
    logic                 sel_valid;
    logic                 sel_last;
    logic                 xfer;

    logic [DATA_WIDTH-1:0] req_word [NUM_REQ];

    // Unpack the per-requester data words.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
        assign req_word[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req      (req_valid),
        .last_gnt (last_gnt),
        .any_c    (pick_any),
        .win_c    (pick_win)
    );

    // State, grant and beat registers.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt_id   <= '0;
            last_gnt <= IDW'(NUM_REQ - 1);
            beat_cnt <= '0;
        end else begin
            state    <= state_d;
            gnt_id   <= gnt_id_d;
            last_gnt <= last_gnt_d;
            beat_cnt <= beat_cnt_d;
        end
    end

    // Next-state and port decode; handshake outputs follow state so reset kills them at once.
    always_comb begin
        state_d    = state;
        gnt_id_d   = gnt_id;
        last_gnt_d = last_gnt;
        beat_cnt_d = beat_cnt;
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        sel_valid  = req_valid[gnt_id];
        sel_last   = req_last[gnt_id];
        fifo_din   = req_word[gnt_id];
        xfer       = 1'b0;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_d    = BURST;
                    gnt_id_d   = pick_win;
                    last_gnt_d = pick_win;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                req_ready[gnt_id] = !fifo_full;
                xfer              = sel_valid && !fifo_full;
                fifo_wr_en        = xfer;
                if (!sel_valid) begin
                    state_d = IDLE;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt + BCW'(1);
                    if (sel_last || (beat_cnt == BEAT_END)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt_valid = (state == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic
// against a cycle-level behavioural model of grant ownership.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 8;

    logic            wr_clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_din;
    logic            gnt_valid;
    logic [1:0]      gnt_id;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .wr_clk     (wr_clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always #5 wr_clk = ~wr_clk;

    int n_total = 0;
    int n_bad   = 0;

    // Per-requester word queues: bit 8 is the last flag.
    logic [8:0] qmem [N][256];
    int         qh [N];
    int         qt [N];
    logic [N-1:0] en;
    logic       full_now;

    // Model: who owns the port (-1 none), words moved in this grant, previous winner.
    int m_owner;
    int m_last;
    int m_beats;

    // Observed burst log taken from the DUT outputs.
    int         obs_cnt;
    int         obs_len [$];
    int         obs_id  [$];
    logic [7:0] obs_dat [$];
    int         e_len   [$];
    int         e_id    [$];
    logic [7:0] e_dat   [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input int r, input logic [7:0] d, input logic last);
        qmem[r][qt[r] % 256] = {last, d};
        qt[r]++;
    endtask

    task automatic drive();
        logic [8:0] w;
        for (int i = 0; i < N; i++) begin
            w               = qmem[i][qh[i] % 256];
            req_valid[i]    = en[i] && (qt[i] > qh[i]);
            req_last[i]     = w[8];
            req_data[i*DW +: DW] = w[7:0];
        end
        fifo_full = full_now;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_beats = 0;
    endtask

    task automatic obs_clear();
        obs_cnt = 0;
        obs_len.delete();
        obs_id.delete();
        obs_dat.delete();
        e_len.delete();
        e_id.delete();
        e_dat.delete();
    endtask

    // Check outputs for the current cycle, log transfers, advance the model.
    task automatic step();
        logic [N-1:0] exp_ready;
        logic         exp_wr;
        int           own;
        int           c;
        #1;
        own       = m_owner;
        exp_ready = '0;
        exp_wr    = 1'b0;
        if (own >= 0) begin
            if (!fifo_full) exp_ready[own] = 1'b1;
            exp_wr = req_valid[own] && !fifo_full;
        end
        chk("wr_en", 32'(fifo_wr_en), 32'(exp_wr));
        chk("ready", 32'(req_ready), 32'(exp_ready));
        chk("gnt_valid", 32'(gnt_valid), 32'(own >= 0));
        if (own >= 0) chk("gnt_id", 32'(gnt_id), 32'(own));
        if (exp_wr) chk("din", 32'(fifo_din), 32'(qmem[own][qh[own] % 256][7:0]));

        if (fifo_wr_en) begin
            if (obs_cnt == 0) obs_id.push_back(int'(gnt_id));
            obs_cnt++;
            obs_dat.push_back(fifo_din);
        end else if (!gnt_valid && obs_cnt > 0) begin
            obs_len.push_back(obs_cnt);
            obs_cnt = 0;
        end

        if (own < 0) begin
            for (int j = 1; j <= N; j++) begin
                c = (m_last + j) % N;
                if (m_owner < 0 && req_valid[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_beats = 0;
                end
            end
        end else if (!req_valid[own]) begin
            m_owner = -1;
        end else if (exp_wr) begin
            m_beats++;
            qh[own]++;
            if (req_last[own] || m_beats == MB) m_owner = -1;
        end
    endtask

    task automatic cycle();
        drive();
        step();
        @(negedge wr_clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic chk_bursts(input string tag);
        chk({tag, "_count"}, 32'(obs_len.size()), 32'(e_len.size()));
        for (int k = 0; k < e_len.size(); k++) begin
            if (k < obs_len.size() && k < obs_id.size()) begin
                chk({tag, "_len"}, 32'(obs_len[k]), 32'(e_len[k]));
                chk({tag, "_id"}, 32'(obs_id[k]), 32'(e_id[k]));
            end
        end
        chk({tag, "_words"}, 32'(obs_dat.size()), 32'(e_dat.size()));
        for (int k = 0; k < e_dat.size(); k++) begin
            if (k < obs_dat.size()) chk({tag, "_data"}, 32'(obs_dat[k]), 32'(e_dat[k]));
        end
        for (int r = 0; r < N; r++) chk({tag, "_drain"}, 32'(qt[r] - qh[r]), 32'(0));
    endtask

    initial begin
        int len;
        rst       = 1'b1;
        en        = '1;
        full_now  = 1'b0;
        for (int r = 0; r < N; r++) begin
            qh[r] = 0;
            qt[r] = 0;
            for (int k = 0; k < 256; k++) qmem[r][k] = '0;
        end
        drive();
        model_reset();
        obs_clear();

        // Reset values.
        @(negedge wr_clk);
        #1;
        chk("rst_gnt_valid", 32'(gnt_valid), 32'(0));
        chk("rst_gnt_id", 32'(gnt_id), 32'(0));
        chk("rst_wr_en", 32'(fifo_wr_en), 32'(0));
        chk("rst_ready", 32'(req_ready), 32'(0));
        @(negedge wr_clk);
        rst = 1'b0;

        // Fairness: all four hold 2-word packets; order 0,1,2,3 repeating.
        for (int p = 0; p < 3; p++) begin
            for (int r = 0; r < N; r++) begin
                push_word(r, 8'(r*16 + p*2), 1'b0);
                push_word(r, 8'(r*16 + p*2 + 1), 1'b1);
                e_id.push_back(r);
                e_len.push_back(2);
                e_dat.push_back(8'(r*16 + p*2));
                e_dat.push_back(8'(r*16 + p*2 + 1));
            end
        end
        run(45);
        chk_bursts("fair");

        // Single requester, 3-word packet.
        obs_clear();
        push_word(0, 8'h11, 1'b0);
        push_word(0, 8'h22, 1'b0);
        push_word(0, 8'h33, 1'b1);
        e_id  = '{0};
        e_len = '{3};
        e_dat = '{8'h11, 8'h22, 8'h33};
        run(8);
        chk_bursts("single");

        // Burst limit: 20 words with no last split 8/8/4.
        obs_clear();
        for (int k = 0; k < 20; k++) begin
            push_word(1, 8'(8'h40 + k), 1'b0);
            e_dat.push_back(8'(8'h40 + k));
        end
        e_id  = '{1, 1, 1};
        e_len = '{8, 8, 4};
        run(32);
        chk_bursts("limit");

        // Full stall for 5 cycles in the middle of req 2's burst.
        obs_clear();
        for (int k = 0; k < 6; k++) begin
            push_word(2, 8'(8'hA0 + k), k == 5);
            e_dat.push_back(8'(8'hA0 + k));
        end
        e_id  = '{2};
        e_len = '{6};
        run(3);
        full_now = 1'b1;
        run(5);
        full_now = 1'b0;
        run(10);
        chk_bursts("stall");

        // Idle release: req 3 drops valid after one word while req 1 waits.
        obs_clear();
        en[1] = 1'b0;
        push_word(3, 8'h77, 1'b0);
        push_word(1, 8'h51, 1'b0);
        push_word(1, 8'h52, 1'b0);
        push_word(1, 8'h53, 1'b1);
        e_id  = '{3, 1};
        e_len = '{1, 3};
        e_dat = '{8'h77, 8'h51, 8'h52, 8'h53};
        cycle();
        en[1] = 1'b1;
        run(12);
        chk_bursts("release");

        // Reset in the middle of req 1's burst; requester 0 must win afterwards.
        obs_clear();
        for (int k = 0; k < 6; k++) push_word(1, 8'(8'h60 + k), k == 5);
        run(3);
        push_word(0, 8'h01, 1'b0);
        push_word(0, 8'h02, 1'b0);
        push_word(0, 8'h03, 1'b1);
        push_word(2, 8'h21, 1'b0);
        push_word(2, 8'h22, 1'b1);
        drive();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_wr_en", 32'(fifo_wr_en), 32'(0));
        chk("mid_rst_ready", 32'(req_ready), 32'(0));
        chk("mid_rst_gnt_valid", 32'(gnt_valid), 32'(0));
        chk("mid_rst_gnt_id", 32'(gnt_id), 32'(0));
        model_reset();
        obs_clear();
        @(negedge wr_clk);
        rst = 1'b0;
        e_id  = '{0, 1, 2};
        e_len = '{3, 4, 2};
        e_dat = '{8'h01, 8'h02, 8'h03, 8'h62, 8'h63, 8'h64, 8'h65, 8'h21, 8'h22};
        run(30);
        chk_bursts("rst_resume");

        // Random traffic: random packets, valid gaps and full stalls.
        obs_clear();
        for (int k = 0; k < 400; k++) begin
            for (int r = 0; r < N; r++) begin
                if ((qt[r] - qh[r]) < 4 && $urandom_range(0, 2) == 0) begin
                    len = int'($urandom_range(1, 12));
                    for (int w = 0; w < len; w++) push_word(r, 8'($urandom), w == len - 1);
                end
                en[r] = ($urandom_range(0, 7) != 0);
            end
            full_now = ($urandom_range(0, 4) == 0);
            cycle();
        end
        en       = '1;
        full_now = 1'b0;
        run(200);
        for (int r = 0; r < N; r++) chk("rand_drain", 32'(qt[r] - qh[r]), 32'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
